fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// requester-id width helper and the stall counter width.
package fifo_arb_pkg;

  // Arbiter state encoding (kept as plain constants for older tool flows)
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Width of the optional blocked-cycle counter
  localparam int STALL_CNT_W = 16;

  // Bits needed to name one of n requesters; a single requester still gets one bit
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first valid requester after
// last_grant, wrapping around. Pure logic, so it can be reused on a read side.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] winner,
  output logic            any_valid
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  int             pos;

  // Rotating the doubled vector puts requester last_grant+1 at bit 0
  assign doubled   = {valid, valid};
  assign rotated   = N'(doubled >> (int'(last_grant) + 1));
  assign any_valid = |valid;

  // Scan from the far end down so the nearest valid requester overwrites the rest
  always_comb begin
    winner = '0;
    pos    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        pos = int'(last_grant) + 1 + i;
        if (pos >= N) pos = pos - N;
        winner = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ requesters.
// A grant is held for a whole packet, capped at MAX_BURST beats, and every
// accepted beat is written straight into the FIFO, gated by fifo_full.
// Optional build macro: FIFO_ARB_STALL_CNT_EN adds stall_clr / stall_cnt,
// a saturating count of cycles the granted requester was blocked by a full FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_width = 8,
  parameter  int N_REQ      = 4,
  parameter  int MAX_BURST  = 8,
  localparam int ID_W       = id_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_width-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_width-1:0]       fifo_data,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  input  logic                        stall_clr,
  output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

  localparam int                BCNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(MAX_BURST - 1);

  logic [0:0]        state;
  logic [ID_W-1:0]   last_grant;
  logic [BCNT_W-1:0] beat_cnt;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic [N_REQ-1:0]  grant_oh;
  logic              g_valid;
  logic              g_last;
  logic              accept;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .winner     (pick_id),
    .any_valid  (pick_any)
  );

  // Steer the granted requester onto the write port; everything is quiet in IDLE
  assign busy       = (state == XFER);
  assign grant_oh   = N_REQ'(1) << grant_id;
  assign g_valid    = |(req_valid & grant_oh);
  assign g_last     = |(req_last & grant_oh);
  assign accept     = busy & g_valid & ~fifo_full;
  assign req_ready  = (busy && !fifo_full) ? grant_oh : '0;
  assign fifo_wr_en = accept;
  assign fifo_data  = busy ? DATA_width'(req_data >> (int'(grant_id) * DATA_width)) : '0;

  // Grant FSM: arbitrate for one cycle in IDLE, then move beats until last or the burst cap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            beat_cnt   <= '0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (g_last || beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  // Count cycles the granted requester has data but the FIFO is full; clear wins, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (busy && g_valid && fifo_full && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Blocked-cycle instrumentation is not built in this configuration
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N_REQ=4, DATA_width=8, MAX_BURST=8).
// Requester sources are queues of {last, data} beats that advance only when
// accepted; each expected FIFO write {id, data} is queued as stimulus is issued
// and compared when the DUT raises fifo_wr_en.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic           stall_clr;
  logic [15:0]    stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0]   src_q [N][$];
  logic [9:0]   exp_q [$];
  logic [N-1:0] gap = '0;
  logic [N-1:0] accepted;
  logic         wr_seen;

  fifo_wr_arbiter #(
    .DATA_width (W),
    .N_REQ      (N),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_clr  (stall_clr),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Free-running write clock
  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Queue a packet of beats (data base, base+1, ...) on one requester
  task automatic applyStimulus(input int id, input int beats, input logic [7:0] base);
    logic [7:0] d;
    for (int k = 0; k < beats; k++) begin
      d = base + 8'(k);
      src_q[id].push_back({(k == beats - 1), d});
    end
  endtask

  // Queue the FIFO writes these beats should produce, in predicted order
  task automatic expectBeats(input int id, input logic [7:0] base, input int first, input int count);
    logic [7:0] d;
    for (int k = first; k < first + count; k++) begin
      d = base + 8'(k);
      exp_q.push_back({2'(id), d});
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Present the head beat of every source that is not deliberately paused
  task automatic drive();
    logic [8:0] f;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 && !gap[i]) begin
        f = src_q[i][0];
        req_valid[i]         = 1'b1;
        req_last[i]          = f[8];
        req_data[i*W +: W]   = f[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // Sample outputs mid-cycle: score writes and confirm a full FIFO blocks everything
  task automatic monitor();
    logic [9:0] e;
    accepted = req_valid & req_ready;
    wr_seen  = fifo_wr_en;
    if (fifo_wr_en) begin
      checkOutput("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("wr_id", 32'(grant_id), 32'(e[9:8]));
        checkOutput("wr_data", 32'(fifo_data), 32'(e[7:0]));
      end
    end
    if (fifo_full) checkOutput("full_blocks", 32'({fifo_wr_en, req_ready}), 0);
  endtask

  // One clock: sample at negedge, then retire accepted beats just after posedge
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (accepted[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < budget) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(exp_q.size() != 0 || pending()), 0);
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    gap       = '0;
`ifdef FIFO_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Directed scenarios, run back to back
  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ready", 32'(req_ready), 0);
    checkOutput("rst_wr_en", 32'(fifo_wr_en), 0);
    checkOutput("rst_data", 32'(fifo_data), 0);
`ifdef FIFO_ARB_STALL_CNT_EN
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
`endif

    // Single 3-beat packet from requester 0
    $display("[TB] single packet");
    applyStimulus(0, 3, 8'h10);
    expectBeats(0, 8'h10, 0, 3);
    drive();
    cycle();
    checkOutput("single_arb_no_wr", 32'(wr_seen), 0);
    checkOutput("single_busy", 32'(busy), 1);
    checkOutput("single_grant", 32'(grant_id), 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("single_wr_run", 32'(wr_seen), 1);
    end
    checkOutput("single_idle", 32'(busy), 0);
    checkOutput("single_sb", 32'(exp_q.size()), 0);

    // Round-robin over four continuous one-beat requesters
    $display("[TB] round robin");
    do_reset();
    applyStimulus(0, 1, 8'h20);
    applyStimulus(0, 1, 8'h24);
    applyStimulus(1, 1, 8'h21);
    applyStimulus(2, 1, 8'h22);
    applyStimulus(3, 1, 8'h23);
    expectBeats(0, 8'h20, 0, 1);
    expectBeats(1, 8'h21, 0, 1);
    expectBeats(2, 8'h22, 0, 1);
    expectBeats(3, 8'h23, 0, 1);
    expectBeats(0, 8'h24, 0, 1);
    drive();
    for (int k = 0; k < 10; k++) begin
      cycle();
      checkOutput("rr_idle_gap", 32'(wr_seen), 32'(k % 2));
    end
    drain("rr", 10);

    // Burst cap: 20-beat packet from 1 is split around requester 2's packet
    $display("[TB] burst cap");
    do_reset();
    applyStimulus(1, 20, 8'h40);
    applyStimulus(2, 3, 8'h80);
    expectBeats(1, 8'h40, 0, 8);
    expectBeats(2, 8'h80, 0, 3);
    expectBeats(1, 8'h40, 8, 12);
    drive();
    drain("burst", 200);

    // Backpressure for five cycles mid-packet
    $display("[TB] backpressure");
    do_reset();
    applyStimulus(0, 6, 8'hA0);
    expectBeats(0, 8'hA0, 0, 6);
    drive();
    cycle();
    cycle();
    cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checkOutput("bp_no_wr", 32'(wr_seen), 0);
    end
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STALL_CNT_EN
    checkOutput("bp_stall_cnt", 32'(stall_cnt), 5);
    stall_clr = 1'b1;
    cycle();
    stall_clr = 1'b0;
    checkOutput("bp_stall_clr", 32'(stall_cnt), 0);
`endif
    drain("bp", 50);

    // Reset pulled after beat 2 of 4
    $display("[TB] reset mid-packet");
    do_reset();
    applyStimulus(0, 4, 8'hC0);
    expectBeats(0, 8'hC0, 0, 2);
    drive();
    cycle();
    cycle();
    cycle();
    checkOutput("midrst_pre_wr", 32'(fifo_wr_en), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 32'(fifo_wr_en), 0);
    checkOutput("midrst_ready", 32'(req_ready), 0);
    checkOutput("midrst_data", 32'(fifo_data), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_grant", 32'(grant_id), 0);
    checkOutput("midrst_sb", 32'(exp_q.size()), 0);
    src_q[0].delete();
    applyStimulus(2, 1, 8'hD2);
    applyStimulus(0, 1, 8'hD0);
    expectBeats(0, 8'hD0, 0, 1);
    expectBeats(2, 8'hD2, 0, 1);
    drive();
    cycle();
    cycle();
    rst_n = 1'b1;
    drain("midrst", 20);

    // Granted requester drops valid for three cycles without last
    $display("[TB] valid gap");
    do_reset();
    applyStimulus(1, 4, 8'hE0);
    applyStimulus(3, 1, 8'hF3);
    expectBeats(1, 8'hE0, 0, 4);
    expectBeats(3, 8'hF3, 0, 1);
    drive();
    cycle();
    cycle();
    gap = 4'b0010;
    drive();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("gap_no_wr", 32'(wr_seen), 0);
      checkOutput("gap_busy", 32'(busy), 1);
      checkOutput("gap_grant", 32'(grant_id), 1);
    end
    gap = '0;
    drive();
    drain("gap", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
